// File: rtl/mm_write_master_pkg.sv
// mm_write_master_pkg
//   Shared definitions for the memory-mapped write master: the FSM state
//   encoding, the fixed data path width, the byte lane count and the address
//   stride between consecutive words.
package mm_write_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int DATA_BITS   = 32;
  localparam int BYTE_LANES  = 4;
  localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/mm_write_master.sv
// mm_write_master
//   Moves `length` 32-bit words from an external FIFO to consecutive,
//   word-aligned bus addresses starting at `base_addr`. At most one word is in
//   flight at any time: pop, capture, then write and wait for acceptance.
//
// Ports
//   clk              single clock, rising edge
//   reset            synchronous, active-low
//   start            one-cycle request to begin a transfer (ignored while busy)
//   base_addr        byte address of the first write
//   length           number of words to move (0 gives an immediate done)
//   busy             high while a transfer is in progress
//   done             one-cycle completion pulse
//   fifo_read_en     pop request to the upstream FIFO
//   fifo_data        FIFO read data, valid the cycle after a pop
//   fifo_empty       upstream FIFO empty flag
//   avm_address      bus write address (always word aligned)
//   avm_write        bus write strobe
//   avm_writedata    bus write data
//   avm_byteenable   bus byte enables, all lanes always on
//   avm_waitrequest  slave stall; a write is accepted when this is low
module mm_write_master
  import mm_write_master_pkg::*;
#(
  parameter int ADDR_BITS  = 32,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic [COUNT_BITS-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_read_en,
  input  logic [DATA_BITS-1:0]  fifo_data,
  input  logic                  fifo_empty,
  output logic [ADDR_BITS-1:0]  avm_address,
  output logic                  avm_write,
  output logic [DATA_BITS-1:0]  avm_writedata,
  output logic [BYTE_LANES-1:0] avm_byteenable,
  input  logic                  avm_waitrequest
);

  // Clears the two low address bits so every bus address is word aligned.
  localparam logic [ADDR_BITS-1:0] ADDR_MASK = {{(ADDR_BITS-2){1'b1}}, 2'b00};

  state_t state;
  state_t state_next;

  logic [COUNT_BITS-1:0] remaining;
  logic                  accept;
  logic                  last_word;

  assign accept         = (state == ST_WRITE) && avm_write && !avm_waitrequest;
  assign last_word      = (remaining == COUNT_BITS'(1));
  assign avm_byteenable = {BYTE_LANES{1'b1}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. The FIFO pop is combinational so a word can be taken
  // in the same cycle the FIFO becomes non-empty.
  always_comb begin
    state_next   = state;
    fifo_read_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (length != '0)) begin
          state_next = ST_POP;
        end
      end
      ST_POP: begin
        fifo_read_en = !fifo_empty;
        if (!fifo_empty) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (accept) begin
          state_next = last_word ? ST_DONE : ST_POP;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath. The address register is loaded at start so the bus already
  // shows the base address while the first word is being fetched; busy drops
  // together with the done pulse on the final acceptance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      remaining     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length != '0) begin
              avm_address <= base_addr & ADDR_MASK;
              remaining   <= length;
              busy        <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          avm_writedata <= fifo_data;
          avm_write     <= 1'b1;
        end
        ST_WRITE: begin
          if (accept) begin
            avm_write   <= 1'b0;
            avm_address <= avm_address + ADDR_BITS'(WORD_STRIDE);
            remaining   <= remaining - COUNT_BITS'(1);
            if (last_word) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_write_master.sv
// tb_mm_write_master
//   Self-checking bench for mm_write_master. A simple array FIFO model feeds
//   the DUT, and a bus monitor logs every accepted write, pop and done pulse.
//   A cycle-by-cycle vector table covers a basic three-word transfer; directed
//   sequences cover stalls, FIFO underrun, zero length, address wrap and reset.
module tb_mm_write_master;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        fifo_read_en;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;

  int n_compared;
  int n_mismatched;

  // FIFO model: the initial block owns the write side, the clocked block the
  // read side, so each pointer has a single writer.
  logic [31:0] fifo_mem [64];
  int          wr_ptr;
  int          rd_ptr;

  // Monitor logs.
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  int          wr_count;
  int          pop_count;
  int          done_count;

  typedef struct {
    logic        start;
    logic [31:0] base;
    logic [15:0] len;
    logic        wait_req;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  mm_write_master #(
    .ADDR_BITS (32),
    .COUNT_BITS(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .fifo_read_en   (fifo_read_en),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_waitrequest(avm_waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO read side: data appears the cycle after a pop.
  initial rd_ptr = 0;
  always @(posedge clk) begin
    if (fifo_read_en && !fifo_empty) begin
      fifo_data <= fifo_mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Bus monitor.
  initial begin
    wr_count   = 0;
    pop_count  = 0;
    done_count = 0;
  end
  always @(posedge clk) begin
    if (avm_write && !avm_waitrequest && reset) begin
      log_addr[wr_count % 64] <= avm_address;
      log_data[wr_count % 64] <= avm_writedata;
      wr_count                <= wr_count + 1;
    end
    if (fifo_read_en && !fifo_empty) begin
      pop_count <= pop_count + 1;
    end
    if (done) begin
      done_count <= done_count + 1;
    end
  end

  function automatic vec_t mkVec(input logic s, input logic [31:0] b,
                                 input logic [15:0] l, input logic w,
                                 input logic eb, input logic ed,
                                 input logic er, input logic ew,
                                 input logic [31:0] ea, input logic [31:0] edat);
    vec_t v;
    v.start    = s;
    v.base     = b;
    v.len      = l;
    v.wait_req = w;
    v.exp_busy = eb;
    v.exp_done = ed;
    v.exp_rd   = er;
    v.exp_wr   = ew;
    v.exp_addr = ea;
    v.exp_data = edat;
    return v;
  endfunction

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start           = v.start;
    base_addr       = v.base;
    length          = v.len;
    avm_waitrequest = v.wait_req;
    stepClk();
  endtask

  task automatic pushWord(input logic [31:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic startXfer(input logic [31:0] b, input logic [15:0] l);
    start     = 1'b1;
    base_addr = b;
    length    = l;
    stepClk();
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      stepClk();
      n++;
    end
    checkOutput({name, "_done_seen"}, {31'd0, done}, 32'd1);
    checkOutput({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic waitWrites(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (wr_count < target && n < budget) begin
      stepClk();
      n++;
    end
    checkOutput({name, "_write_reached"}, wr_count, target);
  endtask

  initial begin
    int bw;
    int bp;
    int bd;
    int n;

    n_compared   = 0;
    n_mismatched = 0;
    wr_ptr       = 0;

    // Reset with start asserted: reset must win.
    reset           = 1'b0;
    start           = 1'b1;
    base_addr       = 32'h1234;
    length          = 16'd5;
    avm_waitrequest = 1'b0;
    stepClk();
    stepClk();
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_rd_en", {31'd0, fifo_read_en}, 32'd0);
    checkOutput("rst_write", {31'd0, avm_write}, 32'd0);
    checkOutput("rst_addr", avm_address, 32'd0);
    checkOutput("rst_data", avm_writedata, 32'd0);
    checkOutput("byteenable", {28'd0, avm_byteenable}, 32'hF);
    start = 1'b0;
    reset = 1'b1;

    // Basic transfer, checked cycle by cycle. Entry 4 raises start while
    // busy, which must be ignored.
    pushWord(32'hA);
    pushWord(32'hB);
    pushWord(32'hC);
    vecs[0]  = mkVec(1'b1, 32'h1000, 16'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
    vecs[1]  = mkVec(1'b0, 32'h0,    16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h0);
    vecs[2]  = mkVec(1'b0, 32'h0,    16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000, 32'hA);
    vecs[3]  = mkVec(1'b0, 32'h0,    16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1004, 32'hA);
    vecs[4]  = mkVec(1'b1, 32'h5000, 16'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1004, 32'hA);
    vecs[5]  = mkVec(1'b0, 32'h0,    16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1004, 32'hB);
    vecs[6]  = mkVec(1'b0, 32'h0,    16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1008, 32'hB);
    vecs[7]  = mkVec(1'b0, 32'h0,    16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1008, 32'hB);
    vecs[8]  = mkVec(1'b0, 32'h0,    16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1008, 32'hC);
    vecs[9]  = mkVec(1'b0, 32'h0,    16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100C, 32'hC);
    vecs[10] = mkVec(1'b0, 32'h0,    16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100C, 32'hC);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      checkOutput($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
      checkOutput($sformatf("vec%0d_rd_en", i), {31'd0, fifo_read_en}, {31'd0, vecs[i].exp_rd});
      checkOutput($sformatf("vec%0d_write", i), {31'd0, avm_write}, {31'd0, vecs[i].exp_wr});
      checkOutput($sformatf("vec%0d_addr", i), avm_address, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_data", i), avm_writedata, vecs[i].exp_data);
    end
    checkOutput("basic_writes", wr_count, 3);
    checkOutput("basic_log_addr2", log_addr[2], 32'h1008);
    checkOutput("basic_log_data2", log_data[2], 32'hC);

    // Stall the second word for five cycles.
    bw = wr_count;
    bp = pop_count;
    pushWord(32'h11);
    pushWord(32'h22);
    pushWord(32'h33);
    startXfer(32'h2000, 16'd3);
    waitWrites("stall_first", bw + 1, 50);
    avm_waitrequest = 1'b1;
    n = 0;
    while (avm_write !== 1'b1 && n < 50) begin
      stepClk();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall%0d_write", k), {31'd0, avm_write}, 32'd1);
      checkOutput($sformatf("stall%0d_addr", k), avm_address, 32'h2004);
      checkOutput($sformatf("stall%0d_data", k), avm_writedata, 32'h22);
      checkOutput($sformatf("stall%0d_pops", k), pop_count - bp, 2);
      if (k < 4) stepClk();
    end
    avm_waitrequest = 1'b0;
    waitDone("stall", 50);
    checkOutput("stall_writes", wr_count - bw, 3);
    checkOutput("stall_pops", pop_count - bp, 3);
    checkOutput("stall_addr1", log_addr[(bw + 1) % 64], 32'h2004);
    checkOutput("stall_data1", log_data[(bw + 1) % 64], 32'h22);
    checkOutput("stall_addr2", log_addr[(bw + 2) % 64], 32'h2008);
    checkOutput("stall_data2", log_data[(bw + 2) % 64], 32'h33);
    stepClk();

    // FIFO runs dry for ten cycles mid-transfer.
    bw = wr_count;
    pushWord(32'h44);
    startXfer(32'h3000, 16'd2);
    waitWrites("empty_first", bw + 1, 50);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("empty%0d_rd_en", k), {31'd0, fifo_read_en}, 32'd0);
      checkOutput($sformatf("empty%0d_write", k), {31'd0, avm_write}, 32'd0);
      checkOutput($sformatf("empty%0d_busy", k), {31'd0, busy}, 32'd1);
      stepClk();
    end
    checkOutput("empty_no_write", wr_count - bw, 1);
    pushWord(32'h55);
    waitDone("empty", 50);
    checkOutput("empty_addr1", log_addr[(bw + 1) % 64], 32'h3004);
    checkOutput("empty_data1", log_data[(bw + 1) % 64], 32'h55);
    stepClk();

    // Zero-length request.
    bw = wr_count;
    bp = pop_count;
    startXfer(32'h4000, 16'd0);
    checkOutput("zero_done", {31'd0, done}, 32'd1);
    checkOutput("zero_busy", {31'd0, busy}, 32'd0);
    stepClk();
    checkOutput("zero_done_pulse", {31'd0, done}, 32'd0);
    stepClk();
    checkOutput("zero_pops", pop_count - bp, 0);
    checkOutput("zero_writes", wr_count - bw, 0);

    // Address wrap at the top of the address space.
    bw = wr_count;
    pushWord(32'h66);
    pushWord(32'h77);
    startXfer(32'hFFFF_FFFC, 16'd2);
    checkOutput("wrap_base_shown", avm_address, 32'hFFFF_FFFC);
    waitDone("wrap", 50);
    checkOutput("wrap_addr0", log_addr[bw % 64], 32'hFFFF_FFFC);
    checkOutput("wrap_data0", log_data[bw % 64], 32'h66);
    checkOutput("wrap_addr1", log_addr[(bw + 1) % 64], 32'h0000_0000);
    checkOutput("wrap_data1", log_data[(bw + 1) % 64], 32'h77);
    stepClk();

    // Reset during a stalled write, then a fresh single-word transfer.
    bd = done_count;
    pushWord(32'h88);
    avm_waitrequest = 1'b1;
    startXfer(32'h5000, 16'd2);
    n = 0;
    while (avm_write !== 1'b1 && n < 50) begin
      stepClk();
      n++;
    end
    checkOutput("abort_in_write", {31'd0, avm_write}, 32'd1);
    reset = 1'b0;
    stepClk();
    reset           = 1'b1;
    avm_waitrequest = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_rd_en", {31'd0, fifo_read_en}, 32'd0);
    checkOutput("abort_write", {31'd0, avm_write}, 32'd0);
    checkOutput("abort_addr", avm_address, 32'd0);
    checkOutput("abort_data", avm_writedata, 32'd0);
    stepClk();
    stepClk();
    stepClk();
    checkOutput("abort_no_done", done_count - bd, 0);
    bw = wr_count;
    pushWord(32'hAB);
    startXfer(32'h6001, 16'd1);
    waitDone("after_abort", 50);
    checkOutput("after_abort_writes", wr_count - bw, 1);
    checkOutput("after_abort_addr", log_addr[bw % 64], 32'h6000);
    checkOutput("after_abort_data", log_data[bw % 64], 32'hAB);
    stepClk();
    checkOutput("after_abort_dones", done_count - bd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mm_write_master.md
MM_WRITE_MASTER -- requirements
Module: mm_write_master

Interface
REQ-001 Parameter ADDR_BITS, default 32, sets the memory-mapped byte address width.
REQ-002 Parameter COUNT_BITS, default 16, sets the transfer length width in words.
REQ-003 The data path SHALL be fixed at 32 bits with 4 byte lanes.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-005 Port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-006 Port reset, input, 1, synchronous active-low reset.
REQ-007 Port start, input, 1, one-cycle request to begin a transfer.
REQ-008 Port base_addr, input, ADDR_BITS, word-aligned byte address of the first write.
REQ-009 Port length, input, COUNT_BITS, number of 32-bit words to transfer.
REQ-010 Port busy, output, 1, high while a transfer is in progress.
REQ-011 Port done, output, 1, one-cycle pulse when a transfer completes.
REQ-012 Port fifo_read_en, output, 1, pop request to the upstream 32-bit FIFO.
REQ-013 Port fifo_data, input, 32, FIFO read data, valid the cycle after a pop.
REQ-014 Port fifo_empty, input, 1, upstream FIFO empty flag.
REQ-015 Port avm_address, output, ADDR_BITS, bus write address.
REQ-016 Port avm_write, output, 1, bus write strobe.
REQ-017 Port avm_writedata, output, 32, bus write data.
REQ-018 Port avm_byteenable, output, 4, bus byte enables, constant 4'b1111.
REQ-019 Port avm_waitrequest, input, 1, slave stall; high means the write is not accepted.

Function
REQ-020 The FSM SHALL have the states IDLE, POP, CAPTURE, WRITE and DONE.
REQ-021 In IDLE with start=1 and length!=0: the block SHALL latch base_addr and length into internal registers, set busy the next cycle and go to POP.
REQ-022 In IDLE with start=1 and length==0: no bus or FIFO activity, done SHALL pulse the next cycle, and the FSM stays in IDLE.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 In POP: fifo_read_en SHALL equal !fifo_empty (combinational from state), and on a pop the FSM goes to CAPTURE.
REQ-025 In POP with fifo_empty=1: the FSM waits in POP indefinitely with no pop.
REQ-026 In CAPTURE: fifo_data SHALL be registered into avm_writedata, avm_write SHALL be set, and the FSM goes to WRITE.
REQ-027 In WRITE: avm_address, avm_writedata and avm_write SHALL be held stable while avm_waitrequest=1.
REQ-028 A write is accepted on avm_write=1 and avm_waitrequest=0.
REQ-029 On acceptance: avm_write drops, the address increments by 4, and remaining decrements by 1.
REQ-030 After acceptance: if remaining was 1 the FSM goes to DONE, otherwise to POP.
REQ-031 In DONE: done=1 for exactly one cycle, busy=0 from that cycle on, and the FSM returns to IDLE.
REQ-032 Address arithmetic SHALL wrap modulo 2^ADDR_BITS, and bits [1:0] of avm_address SHALL always be 0 (forced).
REQ-033 fifo_read_en SHALL never be asserted outside POP; at most one word is in flight.
REQ-034 Peak throughput SHALL be 1 word per 3 cycles with waitrequest=0.
REQ-035 avm_address SHALL show the latched base address from the cycle after start.

Reset
REQ-036 On reset=0 at a clock edge: FSM to IDLE; busy, done, fifo_read_en and avm_write set to 0; avm_address and avm_writedata set to 0; internal counters cleared.
REQ-037 Reset mid-transfer SHALL abandon the transfer without a done pulse; a word popped but not yet written is discarded.
REQ-038 Reset SHALL take priority over start in the same cycle.

Structure
REQ-039 A shared package SHALL hold the FSM state encoding, the byte lane count (4) and the word stride constant (4).
REQ-040 The block SHALL be one module with no sub-module; the FIFO is external.

Verification
REQ-041 Bench SHALL cover: base_addr=0x1000, length=3, FIFO holding 0xA,0xB,0xC, waitrequest=0 -> writes 0x1000=0xA, 0x1004=0xB, 0x1008=0xC, done one cycle after the last accept, busy low.
REQ-042 Bench SHALL cover: waitrequest held high for 5 cycles on the second word -> address, data and write stable for all 5 cycles, a single accept, and no extra pop.
REQ-043 Bench SHALL cover: FIFO empty for 10 cycles mid-transfer -> fifo_read_en low, no bus write, and resumption after fifo_empty falls.
REQ-044 Bench SHALL cover: length=0 start -> done next cycle, zero pops, zero writes.
REQ-045 Bench SHALL cover: base_addr=0xFFFFFFFC, length=2 -> writes to 0xFFFFFFFC then 0x00000000.
REQ-046 Bench SHALL cover: reset asserted during WRITE, then a new start with length=1 -> all outputs 0 after reset, no done for the aborted transfer, and a correct single write afterwards.
